// File: rtl/key_debounce_multi.sv
// ============================================================================
//  Module   : key_debounce_multi
//  Purpose  : N-channel key debouncer with a 2-FF synchroniser and a 4-state
//             debounce FSM per channel. It produces a stable level plus
//             press/release pulses. The optional long-press pulse is enabled
//             by defining KEY_LONG_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce_multi #(
   parameter int N_KEYS       = 4,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int CNT_W        = 20,
   parameter int ACTIVE_LOW   = 1,
   parameter int LONG_CYC     = 50_000_000,
   parameter int LONG_W       = 26
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] in,
   output logic [N_KEYS-1:0] level,
   output logic [N_KEYS-1:0] press,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] long
);

   localparam logic [1:0]       c_ST_IDLE       = 2'd0;
   localparam logic [1:0]       c_ST_PRESS_DB   = 2'd1;
   localparam logic [1:0]       c_ST_HELD       = 2'd2;
   localparam logic [1:0]       c_ST_RELEASE_DB = 2'd3;
   localparam logic [CNT_W-1:0] c_DB_LAST       = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic             c_REL_LVL       = (ACTIVE_LOW != 0);

   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      logic [1:0]       sync_q, sync_d;
      logic [1:0]       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             level_q, level_d;
      logic             press_q, press_d;
      logic             release_q, release_d;
      logic             key_on;
      logic             db_done;

      // Normalised synchroniser output: 1 means pressed regardless of polarity.
      assign key_on  = (ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];
      assign db_done = (cnt_q == c_DB_LAST);
      assign sync_d  = {sync_q[0], in[i]};

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync_q    <= {2{c_REL_LVL}};
            state_q   <= c_ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
         end
      end

      always_comb begin
         state_d = state_q;
         case (state_q)
            c_ST_IDLE:       if (key_on) state_d = c_ST_PRESS_DB;
            c_ST_PRESS_DB:   if (!key_on) state_d = c_ST_IDLE;
                             else if (db_done) state_d = c_ST_HELD;
            c_ST_HELD:       if (!key_on) state_d = c_ST_RELEASE_DB;
            c_ST_RELEASE_DB: if (key_on) state_d = c_ST_HELD;
                             else if (db_done) state_d = c_ST_IDLE;
            default:         state_d = c_ST_IDLE;
         endcase
      end

      // Counter restarts on every state change, so it never passes c_DB_LAST.
      always_comb begin
         cnt_d     = '0;
         level_d   = level_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         case (state_q)
            c_ST_PRESS_DB: begin
               if (key_on && db_done) begin
                  press_d = 1'b1;
                  level_d = 1'b1;
               end else if (key_on) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            c_ST_RELEASE_DB: begin
               if (!key_on && db_done) begin
                  release_d = 1'b1;
                  level_d   = 1'b0;
               end else if (!key_on) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            c_ST_IDLE: level_d = 1'b0;
            default:   cnt_d = '0;
         endcase
      end

      assign level[i]         = level_q;
      assign press[i]         = press_q;
      assign release_pulse[i] = release_q;

`ifdef KEY_LONG_EN
      localparam logic [LONG_W-1:0] c_LONG_LAST = LONG_W'(LONG_CYC - 1);
      localparam logic [LONG_W-1:0] c_LONG_SAT  = LONG_W'(LONG_CYC);

      logic [LONG_W-1:0] lcnt_q, lcnt_d;
      logic              long_q, long_d;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            lcnt_q <= '0;
            long_q <= 1'b0;
         end else begin
            lcnt_q <= lcnt_d;
            long_q <= long_d;
         end
      end

      // Saturating one past the pulse point gives exactly one pulse per press.
      always_comb begin
         lcnt_d = lcnt_q;
         long_d = 1'b0;
         if (state_q == c_ST_PRESS_DB && state_d == c_ST_HELD) begin
            lcnt_d = '0;
         end else if (state_q == c_ST_HELD || state_q == c_ST_RELEASE_DB) begin
            if (lcnt_q != c_LONG_SAT) lcnt_d = lcnt_q + 1'b1;
            long_d = (lcnt_q == c_LONG_LAST);
         end
      end

      assign long[i] = long_q;
`else
      assign long[i] = 1'b0;
`endif
   end

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
// ============================================================================
//  Module   : tb_key_debounce_multi
//  Purpose  : Scoreboard bench for key_debounce_multi (long-press checks
//             follow KEY_LONG_EN).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_debounce_multi;
   localparam int DB  = 16;
   localparam int LAT = DB + 3;
   localparam int LC  = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] in;
   logic [3:0] level, press, rel, lng;

   always #5 clk = ~clk;

   key_debounce_multi #(
      .N_KEYS(4), .DEBOUNCE_CYC(DB), .CNT_W(5), .ACTIVE_LOW(1),
      .LONG_CYC(LC), .LONG_W(7)
   ) dut (
      .clk(clk), .rst(rst), .in(in), .level(level),
      .press(press), .release_pulse(rel), .long(lng)
   );

   typedef struct {
      int         cyc;
      logic [3:0] p, r, l, lvl;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int c, input logic [3:0] p, input logic [3:0] r,
                       input logic [3:0] l, input logic [3:0] lvl);
      exp_t x;
      x.cyc = c; x.p = p; x.r = r; x.l = l; x.lvl = lvl;
      q.push_back(x);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every cycle with a pulse must match the next scoreboard entry.
   always @(negedge clk) begin
      if (rst === 1'b1 && (press | rel | lng) !== 4'h0) begin
         n_checks++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: cycle %0d press=%h release=%h long=%h, expected none",
                     cyc, press, rel, lng);
         end else begin
            e = q.pop_front();
            if (cyc != e.cyc || press !== e.p || rel !== e.r || lng !== e.l || level !== e.lvl) begin
               n_fail++;
               $display("FAIL pulse_event: got cyc=%0d p=%h r=%h l=%h lvl=%h, expected cyc=%0d p=%h r=%h l=%h lvl=%h",
                        cyc, press, rel, lng, level, e.cyc, e.p, e.r, e.l, e.lvl);
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      in  = 4'h0;

      // all keys held through reset
      wait_cyc(3);
      check("rst_level", level, 4'h0);
      check("rst_press", press, 4'h0);
      check("rst_release", rel, 4'h0);
      check("rst_long", lng, 4'h0);
      rst = 1'b1;
      push(cyc + LAT, 4'hF, 4'h0, 4'h0, 4'hF);
      wait_cyc(25);
      check("t1_level_held", level, 4'hF);
      in = 4'hF;
      push(cyc + LAT, 4'h0, 4'hF, 4'h0, 4'h0);
      wait_cyc(25);
      check("t1_level_rel", level, 4'h0);

      // clean press and release on key 0
      in[0] = 1'b0;
      push(cyc + LAT, 4'h1, 4'h0, 4'h0, 4'h1);
      wait_cyc(30);
      check("t2_level_press", level, 4'h1);
      in[0] = 1'b1;
      push(cyc + LAT, 4'h0, 4'h1, 4'h0, 4'h0);
      wait_cyc(30);
      check("t2_level_release", level, 4'h0);

      // bouncing key 1: never accepted
      for (int s = 0; s < 12; s++) begin
         in[1] = s[0];
         wait_cyc(5);
         check("t3_bounce_level", level, 4'h0);
      end
      in[1] = 1'b1;
      wait_cyc(30);
      check("t3_after_bounce", level, 4'h0);

      // key 2: release glitch while held
      in[2] = 1'b0;
      push(cyc + LAT, 4'h4, 4'h0, 4'h0, 4'h4);
      wait_cyc(20);
      in[2] = 1'b1;
      wait_cyc(10);
      in[2] = 1'b0;
      wait_cyc(16);
      check("t4_level_glitch", level, 4'h4);
      in[2] = 1'b1;
      push(cyc + LAT, 4'h0, 4'h4, 4'h0, 4'h0);
      wait_cyc(25);
      check("t4_level_release", level, 4'h0);

      // simultaneous keys 3 and 0
      in = 4'b0110;
      push(cyc + LAT, 4'h9, 4'h0, 4'h0, 4'h9);
      wait_cyc(22);
      check("t5_level_both", level, 4'h9);
      in = 4'hF;
      push(cyc + LAT, 4'h0, 4'h9, 4'h0, 4'h0);
      wait_cyc(25);

      // reset in the middle of debouncing key 1
      in[1] = 1'b0;
      wait_cyc(8);
      rst = 1'b0;
      wait_cyc(1);
      check("t5_rst_level", level, 4'h0);
      check("t5_rst_press", press, 4'h0);
      wait_cyc(2);
      rst = 1'b1;
      push(cyc + LAT, 4'h2, 4'h0, 4'h0, 4'h2);
      wait_cyc(25);
      check("t5_redebounce", level, 4'h2);
      in[1] = 1'b1;
      push(cyc + LAT, 4'h0, 4'h2, 4'h0, 4'h0);
      wait_cyc(25);

      // long hold on key 0
      in[0] = 1'b0;
      push(cyc + LAT, 4'h1, 4'h0, 4'h0, 4'h1);
`ifdef KEY_LONG_EN
      push(cyc + LAT + LC, 4'h0, 4'h0, 4'h1, 4'h1);
`endif
      for (int s = 0; s < 4; s++) begin
         wait_cyc(50);
         check("t6_level_hold", level, 4'h1);
`ifndef KEY_LONG_EN
         check("t6_long_off", lng, 4'h0);
`endif
      end
      in[0] = 1'b1;
      push(cyc + LAT, 4'h0, 4'h1, 4'h0, 4'h0);
      wait_cyc(25);
      check("t6_level_release", level, 4'h0);

      for (int s = 0; s < 50 && q.size() != 0; s++) wait_cyc(1);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_pulses: %0d expected events not seen, required 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule

`default_nettype wire
